// File: rtl/booth_seq_arbiter.sv
// Radix-2 Booth sequential signed multiplier shared by two round-robin requesters.
// Optional BOOTH_ZERO_SKIP_EN: zero operands finish in one cycle with a zero product.
module booth_seq_arbiter #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_req,
    input  logic [WIDTH-1:0]     a_in1,
    input  logic [WIDTH-1:0]     a_in2,
    output logic                 a_ack,
    input  logic                 b_req,
    input  logic [WIDTH-1:0]     b_in1,
    input  logic [WIDTH-1:0]     b_in2,
    output logic                 b_ack,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic                 out_id,
    output logic                 busy
);

    localparam int PW = 2*WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [PW-1:0]      p;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;
    logic               owner;
    logic               rr_last;

    logic               grant_any;
    logic               grant_b;
    logic [WIDTH-1:0]   sel_in1;
    logic [WIDTH-1:0]   sel_in2;
    logic [WIDTH:0]     upper_ext;
    logic [WIDTH:0]     mcand_ext;
    logic [WIDTH:0]     sum;
    logic [PW-1:0]      p_next;

    always_comb begin
        grant_any = a_req | b_req;
        if (a_req && b_req)
            grant_b = ~rr_last;
        else
            grant_b = b_req;
        sel_in1 = grant_b ? b_in1 : a_in1;
        sel_in2 = grant_b ? b_in2 : a_in2;
    end

    // Acks are held off while reset is asserted so no grant is ever advertised then.
    assign a_ack = rst_n && (state == IDLE) && grant_any && !grant_b;
    assign b_ack = rst_n && (state == IDLE) && grant_any &&  grant_b;
    assign busy  = (state != IDLE);

    // The sum is kept one bit wider and its true sign is shifted in, so the single
    // overflowing case (mcand = min) still yields an exact product.
    always_comb begin
        upper_ext = {p[PW-1], p[PW-1 -: WIDTH]};
        mcand_ext = {mcand[WIDTH-1], mcand};
        case (p[1:0])
            2'b01:   sum = upper_ext + mcand_ext;
            2'b10:   sum = upper_ext - mcand_ext;
            default: sum = upper_ext;
        endcase
        p_next = {sum, p[WIDTH:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            p         <= '0;
            mcand     <= '0;
            cnt       <= '0;
            owner     <= 1'b0;
            rr_last   <= 1'b1;
            out       <= '0;
            out_valid <= 1'b0;
            out_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (grant_any) begin
                        owner   <= grant_b;
                        rr_last <= grant_b;
                        mcand   <= sel_in1;
                        cnt     <= CNT_INIT;
`ifdef BOOTH_ZERO_SKIP_EN
                        if (sel_in1 == '0 || sel_in2 == '0) begin
                            p         <= '0;
                            out       <= '0;
                            out_id    <= grant_b;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            p     <= {{WIDTH{1'b0}}, sel_in2, 1'b0};
                            state <= RUN;
                        end
`else
                        p     <= {{WIDTH{1'b0}}, sel_in2, 1'b0};
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        out       <= p_next[PW-1:1];
                        out_id    <= owner;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_arbiter.sv
// Directed bench for booth_seq_arbiter; honours BOOTH_ZERO_SKIP_EN for zero-operand latency.
module tb_booth_seq_arbiter;

    localparam int W = 6;
`ifdef BOOTH_ZERO_SKIP_EN
    localparam int LAT_ZERO = 1;
`else
    localparam int LAT_ZERO = 7;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           a_req, b_req;
    logic [W-1:0]   a_in1, a_in2, b_in1, b_in2;
    logic           a_ack, b_ack;
    logic [2*W-1:0] out;
    logic           out_valid, out_id, busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_seq_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_in1     (a_in1),
        .a_in2     (a_in2),
        .a_ack     (a_ack),
        .b_req     (b_req),
        .b_in1     (b_in1),
        .b_in2     (b_in2),
        .b_ack     (b_ack),
        .out       (out),
        .out_valid (out_valid),
        .out_id    (out_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One single-requester operation starting at a negedge with the engine idle.
    task automatic op(input logic who, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [2*W-1:0] exp, input int lat, input string tag);
        int n;
        if (who) begin b_req = 1'b1; b_in1 = x; b_in2 = y; end
        else     begin a_req = 1'b1; a_in1 = x; a_in2 = y; end
        #1;
        chk({tag, "_ack"}, {30'd0, b_ack, a_ack}, who ? 32'd2 : 32'd1);
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        a_in1 = W'($urandom); a_in2 = W'($urandom);
        b_in1 = W'($urandom); b_in2 = W'($urandom);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_out"}, {20'd0, out}, {20'd0, exp});
        chk({tag, "_id"}, {31'd0, out_id}, {31'd0, who});
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hold"}, {20'd0, out}, {20'd0, exp});
    endtask

    initial begin
        int n;
        int prev;
        logic exp_b;

        // Reset with active requests and random operands.
        rst_n = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        a_in1 = W'($urandom); a_in2 = W'($urandom);
        b_in1 = W'($urandom); b_in2 = W'($urandom);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out",   {20'd0, out}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_acks",  {30'd0, b_ack, a_ack}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_id",    {31'd0, out_id}, 32'd0);
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy",  {31'd0, busy}, 32'd0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        // Single-requester directed products.
        op(1'b0, 6'd3,  6'd5,  12'h00F, 7, "a_3x5");
        op(1'b0, 6'h3D, 6'd5,  12'hFF1, 7, "a_m3x5");
        op(1'b0, 6'h20, 6'h20, 12'h400, 7, "a_minxmin");
        op(1'b0, 6'h20, 6'h1F, 12'hC20, 7, "a_minx31");
        op(1'b0, 6'h1F, 6'h3F, 12'hFE1, 7, "a_31xm1");
        op(1'b1, 6'h3D, 6'h3B, 12'h00F, 7, "b_m3xm5");
        op(1'b0, 6'd0,  6'h39, 12'h000, LAT_ZERO, "a_0xm7");
        op(1'b1, 6'd9,  6'd0,  12'h000, LAT_ZERO, "b_9x0");

        // Fresh reset, then both requesters held high: A, B, A, B every 8 cycles.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a_in1 = 6'd2; a_in2 = 6'd3;
        b_in1 = 6'd4; b_in2 = 6'h3E;
        a_req = 1'b1; b_req = 1'b1;
        #1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            exp_b = (k % 2) == 1;
            n = 0;
            while (!(a_ack || b_ack) && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("rr_ack", {30'd0, b_ack, a_ack}, exp_b ? 32'd2 : 32'd1);
            if (k > 0) chk("rr_gap", cyc - prev, 32'd8);
            prev = cyc;
            n = 0;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rr_lat", n, 32'd7);
            chk("rr_out", {20'd0, out}, exp_b ? 32'h0FF8 : 32'h0006);
            chk("rr_id",  {31'd0, out_id}, {31'd0, exp_b});
        end
        @(negedge clk);
        a_req = 1'b0; b_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during T+3 of an A operation while B is requesting.
        op_abort_setup: begin
            a_req = 1'b1; a_in1 = 6'd7; a_in2 = 6'd7;
            #1;
            chk("ab_ack_a", {30'd0, b_ack, a_ack}, 32'd1);
            @(negedge clk);
            a_req = 1'b0;
            b_req = 1'b1; b_in1 = 6'd4; b_in2 = 6'h3E;
            repeat (2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("ab_rst_busy",  {31'd0, busy}, 32'd0);
            chk("ab_rst_valid", {31'd0, out_valid}, 32'd0);
            chk("ab_rst_acks",  {30'd0, b_ack, a_ack}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            a_req = 1'b1; a_in1 = 6'h3B; a_in2 = 6'd7;
            #1;
            chk("ab_a_wins", {30'd0, b_ack, a_ack}, 32'd1);
            @(negedge clk);
            a_req = 1'b0;
            n = 1;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("ab_lat", n, 32'd7);
            chk("ab_out", {20'd0, out}, 32'h0FDD);
            chk("ab_id",  {31'd0, out_id}, 32'd0);
            n = 0;
            while (!b_ack && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("ab_b_next", n, 32'd1);
            @(negedge clk);
            b_req = 1'b0;
            n = 1;
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("ab_b_lat", n, 32'd7);
            chk("ab_b_out", {20'd0, out}, 32'h0FF8);
            chk("ab_b_id",  {31'd0, out_id}, 32'd1);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
